// File: rtl/display_cmd_pkg.sv
// Shared opcodes, parser state encoding and reset defaults for the SPI display command path.
package display_cmd_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h10;
    localparam logic [7:0] OP_BRIGHT = 8'h20;
    localparam logic [7:0] OP_SWAP   = 8'h30;

    localparam logic [7:0] BRIGHT_RESET_DEF = 8'h80;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_PIXELS,
        ST_PARAM,
        ST_CHECK,
        ST_DISCARD
    } state_t;

endpackage

// File: rtl/ss_sync.sv
// Two-flop synchroniser for a raw pin, output forced low during reset.
// Latency: 2 clk. No backpressure (level signal).
module ss_sync (
    input  logic clk,
    input  logic rst,
    input  logic ss,
    output logic ss_s
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= ss;
            sync_q <= meta_q;
        end
    end

    assign ss_s = sync_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Parses framed SPI display commands into framebuffer writes, brightness and swap (SPI_CMD_CHECKSUM_EN adds XOR check byte).
// Latency: every output is registered one clk after the completing rx_valid. No backpressure: one byte per 8 sclk is always accepted.
module spi_cmd_decoder
    import display_cmd_pkg::*;
#(
    parameter int         ADDR_WIDTH   = 11,
    parameter logic [7:0] BRIGHT_RESET = BRIGHT_RESET_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [7:0]            fb_data,
    output logic                  fb_we,
    output logic [7:0]            brightness,
    output logic                  swap,
    output logic [7:0]            err_count
);

    logic ss_s;

    ss_sync u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .ss   (ss),
        .ss_s (ss_s)
    );

    state_t                state_q, state_d;
    logic [7:0]            hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]            fb_data_q, fb_data_d;
    logic                  fb_we_q, fb_we_d;
    logic [7:0]            bright_q, bright_d;
    logic                  swap_q, swap_d;
    logic [7:0]            err_q, err_d;
    logic                  err_inc;
    logic [15:0]           addr16;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
    logic [7:0]            op_q, op_d;
    logic [7:0]            par_q, par_d;
`endif

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        ptr_d     = ptr_q;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        fb_we_d   = 1'b0;
        bright_d  = bright_q;
        swap_d    = 1'b0;
        err_inc   = 1'b0;
        addr16    = {hi_q, rx_data};
`ifdef SPI_CMD_CHECKSUM_EN
        xor_d     = xor_q;
        op_d      = op_q;
        par_d     = par_q;
`endif
        if (!ss_s) begin
            // Frame ended while a command still expected bytes.
            if (state_q inside {ST_ADDR_HI, ST_ADDR_LO, ST_PARAM, ST_CHECK}) begin
                err_inc = 1'b1;
            end
            state_d = ST_CMD;
        end else if (rx_valid) begin
            case (state_q)
                ST_CMD: begin
`ifdef SPI_CMD_CHECKSUM_EN
                    xor_d = rx_data;
                    op_d  = rx_data;
`endif
                    case (rx_data)
                        OP_NOP:    state_d = ST_DISCARD;
                        OP_WRITE:  state_d = ST_ADDR_HI;
                        OP_BRIGHT: state_d = ST_PARAM;
                        OP_SWAP: begin
`ifdef SPI_CMD_CHECKSUM_EN
                            state_d = ST_CHECK;
`else
                            swap_d  = 1'b1;
                            state_d = ST_DISCARD;
`endif
                        end
                        default: begin
                            err_inc = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    endcase
                end
                ST_ADDR_HI: begin
                    hi_d    = rx_data;
                    state_d = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    ptr_d   = addr16[ADDR_WIDTH-1:0];
                    state_d = ST_PIXELS;
                end
                ST_PIXELS: begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = ptr_q;
                    fb_data_d = rx_data;
                    ptr_d     = ptr_q + ADDR_WIDTH'(1);
                end
                ST_PARAM: begin
`ifdef SPI_CMD_CHECKSUM_EN
                    par_d   = rx_data;
                    xor_d   = xor_q ^ rx_data;
                    state_d = ST_CHECK;
`else
                    bright_d = rx_data;
                    state_d  = ST_DISCARD;
`endif
                end
`ifdef SPI_CMD_CHECKSUM_EN
                ST_CHECK: begin
                    if (rx_data == xor_q) begin
                        if (op_q == OP_BRIGHT) begin
                            bright_d = par_q;
                        end else begin
                            swap_d = 1'b1;
                        end
                    end else begin
                        err_inc = 1'b1;
                    end
                    state_d = ST_DISCARD;
                end
`endif
                default: state_d = state_q;
            endcase
        end
        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CMD;
            hi_q      <= '0;
            ptr_q     <= '0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            fb_we_q   <= 1'b0;
            bright_q  <= BRIGHT_RESET;
            swap_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            ptr_q     <= ptr_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            fb_we_q   <= fb_we_d;
            bright_q  <= bright_d;
            swap_q    <= swap_d;
            err_q     <= err_d;
        end
    end

`ifdef SPI_CMD_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_q <= '0;
            op_q  <= '0;
            par_q <= '0;
        end else begin
            xor_q <= xor_d;
            op_q  <= op_d;
            par_q <= par_d;
        end
    end
`endif

    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign fb_we      = fb_we_q;
    assign brightness = bright_q;
    assign swap       = swap_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed frames against a frame-position model of the command decoder, compared every cycle.
module tb_spi_cmd_decoder;

    localparam int AW = 11;
`ifdef SPI_CMD_CHECKSUM_EN
    localparam int CS_OFS = 1;
`else
    localparam int CS_OFS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ss;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          fb_we;
    logic [7:0]    brightness;
    logic          swap;
    logic [7:0]    err_count;

    spi_cmd_decoder #(.ADDR_WIDTH(AW), .BRIGHT_RESET(8'h80)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_we      (fb_we),
        .brightness (brightness),
        .swap       (swap),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit running = 1'b0;

    // Model state: expected outputs plus the bytes of the current frame.
    logic          exp_we, exp_swap;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_data, exp_bright, exp_err;
    logic [7:0]    fq[$];
    bit            in_frame;
    int            we_seen, swap_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic bump_err();
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    endtask

    task automatic model_reset();
        exp_we = 1'b0; exp_swap = 1'b0; exp_addr = '0; exp_data = '0;
        exp_bright = 8'h80; exp_err = 8'h00;
        fq.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (running && !rst) begin
                check("fb_we", fb_we, exp_we);
                check("swap", swap, exp_swap);
                check("brightness", brightness, exp_bright);
                check("err_count", err_count, exp_err);
                if (exp_we) begin
                    check("fb_addr", fb_addr, exp_addr);
                    check("fb_data", fb_data, exp_data);
                end
                if (fb_we) we_seen++;
                if (swap) swap_seen++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int         n, a;
        logic [7:0] op;
        logic       p_we, p_swap, p_err, p_br;
        logic [7:0] br_v;
        p_we = 0; p_swap = 0; p_err = 0; p_br = 0; br_v = 0; a = 0;
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1;
        if (in_frame) begin
            n  = fq.size();
            op = (n == 0) ? b : fq[0];
            if (n == 0 && !(op inside {8'h00, 8'h10, 8'h20, 8'h30})) p_err = 1;
            if (op == 8'h10 && n >= 3) begin
                p_we = 1;
                a = (int'({fq[1], fq[2]}) + n - 3) % (1 << AW);
            end
`ifdef SPI_CMD_CHECKSUM_EN
            if (op == 8'h20 && n == 2) begin
                if (b == (fq[0] ^ fq[1])) begin p_br = 1; br_v = fq[1]; end
                else p_err = 1;
            end
            if (op == 8'h30 && n == 1) begin
                if (b == fq[0]) p_swap = 1;
                else p_err = 1;
            end
`else
            if (op == 8'h20 && n == 1) begin p_br = 1; br_v = b; end
            if (op == 8'h30 && n == 0) p_swap = 1;
`endif
            fq.push_back(b);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        exp_we = p_we;
        if (p_we) begin exp_addr = a[AW-1:0]; exp_data = b; end
        exp_swap = p_swap;
        if (p_br) exp_bright = br_v;
        if (p_err) bump_err();
        @(posedge clk); #1;
        exp_we = 1'b0; exp_swap = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        ss = 1'b1;
        fq.delete();
        in_frame = 1;
        repeat (4) @(posedge clk);
    endtask

    task automatic end_frame();
        int         len;
        logic [7:0] op;
        bit         p_err;
        repeat (2) @(posedge clk); #1;
        ss = 1'b0;
        len = fq.size();
        op = (len > 0) ? fq[0] : 8'h00;
        p_err = (op == 8'h10 && len > 0 && len < 3) || (op == 8'h20 && len < 2 + CS_OFS)
              || (op == 8'h30 && len < 1 + CS_OFS);
        in_frame = 0;
        repeat (3) @(posedge clk); #1;
        if (p_err) bump_err();
        repeat (2) @(posedge clk);
    endtask

    task automatic frame(input logic [7:0] bytes[$]);
        start_frame();
        foreach (bytes[i]) send_byte(bytes[i]);
        end_frame();
    endtask

    int we0, sw0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ss = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        in_frame = 0; we_seen = 0; swap_seen = 0;
        model_reset();
        @(negedge clk);
        check("rst fb_addr", fb_addr, 0);
        check("rst fb_data", fb_data, 0);
        check("rst fb_we", fb_we, 0);
        check("rst swap", swap, 0);
        check("rst err_count", err_count, 0);
        check("rst brightness", brightness, 8'h80);
        @(posedge clk); #1;
        rst = 1'b0;
        running = 1'b1;
        repeat (2) @(posedge clk);

        // Byte while ss is low must be ignored
        send_byte(8'h30);
        check("idle swap count", swap_seen, 0);

`ifdef SPI_CMD_CHECKSUM_EN
        frame('{8'h20, 8'h10, 8'h30});
        check("cs bright ok", brightness, 8'h10);
        frame('{8'h20, 8'h10, 8'h31});
        check("cs bright kept", brightness, 8'h10);
        check("cs err", err_count, 1);
`else
        frame('{8'h20, 8'h3C});
        check("bright value", brightness, 8'h3C);
        check("bright err", err_count, 0);
`endif
        check("bright no we", we_seen, 0);

        we0 = we_seen;
        frame('{8'h10, 8'h07, 8'hFE, 8'hA1, 8'hA2, 8'hA3});
        check("wrap write count", we_seen - we0, 3);
        check("wrap last addr", fb_addr, 11'h000);
        check("wrap last data", fb_data, 8'hA3);

        we0 = we_seen; sw0 = swap_seen;
        frame('{8'h55, 8'h10, 8'h20, 8'h30});
        check("unknown err", err_count, 1 + CS_OFS);
        check("unknown no we", we_seen - we0, 0);
        check("unknown no swap", swap_seen - sw0, 0);
`ifdef SPI_CMD_CHECKSUM_EN
        frame('{8'h30, 8'h30});
`else
        frame('{8'h30});
`endif
        check("swap count", swap_seen - sw0, 1);

        we0 = we_seen;
        frame('{8'h10, 8'h07});
        check("abort err", err_count, 2 + CS_OFS);
        check("abort no we", we_seen - we0, 0);
        frame('{8'h10, 8'h00, 8'h05, 8'h77});
        check("post-abort addr", fb_addr, 11'h005);
        check("post-abort data", fb_data, 8'h77);

        frame('{8'h20});
        check("short bright err", err_count, 3 + CS_OFS);
        frame('{8'h00, 8'h12, 8'h34});
        check("nop err", err_count, 3 + CS_OFS);

        // Asynchronous reset in the middle of a pixel stream
        start_frame();
        send_byte(8'h10); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async fb_we", fb_we, 0);
        check("async fb_addr", fb_addr, 0);
        check("async fb_data", fb_data, 0);
        check("async brightness", brightness, 8'h80);
        check("async err_count", err_count, 0);
        model_reset();
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        we0 = we_seen;
        send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        end_frame();
        check("post-rst no we", we_seen - we0, 0);
        check("post-rst err", err_count, 0);

        // Drive the error counter into saturation
        for (int i = 0; i < 260; i++) frame('{8'h55});
        check("err saturate", err_count, 255);

        running = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
